// File: rtl/ro_heater_sequencer.sv
// Heat-command sequencer for the ring-oscillator heater bank: queues (level, hold)
// commands and replays them as start/stop words, with a stop word on drain or abort.
module ro_heater_sequencer #(
  parameter int MAX_LEVEL    = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_tvalid_i,
  input  logic [C_DATA_WIDTH-1:0] s_tdata_i,
  output logic                    s_tready_o,
  input  logic                    abort_i,
  output logic                    m_tvalid_o,
  output logic [C_DATA_WIDTH-1:0] m_tdata_o,
  input  logic                    m_tready_i,
  output logic [C_DATA_WIDTH-1:0] heater_on_num_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    level_err_o
);

  // state  | meaning
  // IDLE   | nothing playing; pops the next command when the queue is non-empty
  // APPLY  | start word (level) offered downstream
  // HOLD   | level held while the hold counter runs down
  // STOP   | stop word offered downstream
  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_HOLD, S_STOP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MAX_L = 4'(MAX_LEVEL);

  state_t                  state_q, state_d;
  logic [3:0]              level_q, level_d;
  logic [27:0]             cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    rdy_q;
  logic [AW:0]             wptr_q, rptr_q;
  logic [C_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                    pop, flush, push, full, empty;
  logic [C_DATA_WIDTH-1:0] head;
  logic [3:0]              head_lvl;
  logic [27:0]             head_h;

  assign empty      = (wptr_q == rptr_q);
  assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign s_tready_o = rdy_q & ~full;
  // A push landing in the same cycle as a flush is dropped with the rest of the queue.
  assign push       = s_tvalid_i & s_tready_o & ~flush;
  assign head       = mem[rptr_q[AW-1:0]];
  assign head_lvl   = head[3:0];
  assign head_h     = head[31:4];

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= s_tdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdy_q   <= 1'b0;
      state_q <= S_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      if (flush) begin
        rptr_q <= wptr_q;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
      end
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    level_d         = level_q;
    cnt_d           = cnt_q;
    done_d          = 1'b0;
    err_d           = err_q;
    pop             = 1'b0;
    flush           = 1'b0;
    m_tvalid_o      = 1'b0;
    m_tdata_o       = '0;
    heater_on_num_o = '0;

    unique case (state_q)
      S_IDLE: begin
        if (abort_i) begin
          flush = 1'b1;
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        // Abort withdraws the pending start word; the stop word follows next cycle.
        m_tvalid_o      = ~abort_i;
        m_tdata_o       = (level_q != 4'd0) ? 32'd1 : 32'd0;
        heater_on_num_o = {28'd0, level_q};
        if (abort_i) begin
          flush   = 1'b1;
          state_d = S_STOP;
        end else if (m_tready_i) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        heater_on_num_o = {28'd0, level_q};
        if (abort_i) begin
          flush   = 1'b1;
          state_d = S_STOP;
        end else if (cnt_q == 28'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_APPLY;
          end else begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q - 28'd1;
        end
      end
      S_STOP: begin
        m_tvalid_o = 1'b1;
        if (abort_i) begin
          flush = 1'b1;
        end else if (m_tready_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Popped command: clamp the level and preload max(H,1)-1 into the hold counter.
    if (pop) begin
      level_d = (head_lvl > MAX_L) ? MAX_L : head_lvl;
      if (head_lvl > MAX_L) err_d = 1'b1;
      cnt_d = (head_h == 28'd0) ? 28'd0 : head_h - 28'd1;
    end
  end

  assign busy_o      = (state_q != S_IDLE) | ~empty;
  assign done_o      = done_q;
  assign level_err_o = err_q;

endmodule

// File: tb/tb_ro_heater_sequencer.sv
// Directed bench for ro_heater_sequencer: hand-computed expectations checked with
// immediate assertions, sampled 1 ns after each rising edge.
module tb_ro_heater_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tready;
  logic        abort;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tready;
  logic [31:0] heater_on_num;
  logic        busy;
  logic        done;
  logic        level_err;

  int n_vec = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  ro_heater_sequencer #(.MAX_LEVEL(5), .FIFO_DEPTH(4), .C_DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_tvalid_i      (s_tvalid),
    .s_tdata_i       (s_tdata),
    .s_tready_o      (s_tready),
    .abort_i         (abort),
    .m_tvalid_o      (m_tvalid),
    .m_tdata_o       (m_tdata),
    .m_tready_i      (m_tready),
    .heater_on_num_o (heater_on_num),
    .busy_o          (busy),
    .done_o          (done),
    .level_err_o     (level_err)
  );

  function automatic logic [31:0] cmd(input int lvl, input int h);
    return {28'(h), 4'(lvl)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until m_tvalid is high; n is the number of edges taken (200 means timeout).
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (m_tvalid !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  int exp_lv[4] = '{2, 4, 5, 3};

  initial begin
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; abort = 1'b0; m_tready = 1'b1;
    #2;
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_s_tready", {31'd0, s_tready}, 32'd1);

    // Single command level 3, H=10
    s_tvalid = 1'b1; s_tdata = cmd(3, 10);
    tick();
    s_tvalid = 1'b0;
    chk("t1_busy_queued", {31'd0, busy}, 32'd1);
    chk("t1_no_valid_yet", {31'd0, m_tvalid}, 32'd0);
    tick();
    chk("t1_apply_valid", {31'd0, m_tvalid}, 32'd1);
    chk("t1_apply_tdata", m_tdata, 32'd1);
    chk("t1_apply_level", heater_on_num, 32'd3);
    tick();
    chk("t1_hold_level", heater_on_num, 32'd3);
    wait_valid(n);
    chk("t1_hold_len", n, 32'd10);
    chk("t1_stop_tdata", m_tdata, 32'd0);
    chk("t1_stop_level", heater_on_num, 32'd0);
    tick();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy_fall", {31'd0, busy}, 32'd0);
    tick();
    chk("t1_done_one_cycle", {31'd0, done}, 32'd0);

    // Back-to-back (1,2) (5,4) (2,0)
    s_tvalid = 1'b1; s_tdata = cmd(1, 2);
    tick();
    s_tdata = cmd(5, 4);
    tick();
    chk("t2_c1_level", heater_on_num, 32'd1);
    chk("t2_c1_tdata", m_tdata, 32'd1);
    s_tdata = cmd(2, 0);
    tick();
    s_tvalid = 1'b0;
    wait_valid(n);
    chk("t2_hold1", n, 32'd2);
    chk("t2_c2_level", heater_on_num, 32'd5);
    chk("t2_c2_tdata", m_tdata, 32'd1);
    tick();
    wait_valid(n);
    chk("t2_hold2", n, 32'd4);
    chk("t2_c3_level", heater_on_num, 32'd2);
    chk("t2_c3_tdata", m_tdata, 32'd1);
    tick();
    wait_valid(n);
    chk("t2_hold3", n, 32'd1);
    chk("t2_stop_tdata", m_tdata, 32'd0);
    chk("t2_stop_level", heater_on_num, 32'd0);
    tick();
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_err_clear", {31'd0, level_err}, 32'd0);

    // Level clamp
    s_tvalid = 1'b1; s_tdata = cmd(9, 1);
    tick();
    s_tvalid = 1'b0;
    tick();
    chk("t3_clamp_level", heater_on_num, 32'd5);
    chk("t3_level_err", {31'd0, level_err}, 32'd1);
    tick();
    wait_valid(n);
    chk("t3_hold", n, 32'd1);
    tick();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_err_sticky", {31'd0, level_err}, 32'd1);

    // Fill queue under back-pressure; 6th push refused
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = cmd(1, 1);
    tick();
    s_tdata = cmd(2, 1);
    tick();
    chk("t4_stall_level_a", heater_on_num, 32'd1);
    s_tdata = cmd(4, 1);
    tick();
    s_tdata = cmd(5, 1);
    tick();
    chk("t4_stall_tdata_b", m_tdata, 32'd1);
    s_tdata = cmd(3, 1);
    tick();
    chk("t4_full_ready", {31'd0, s_tready}, 32'd0);
    s_tdata = cmd(1, 20);
    tick();
    s_tvalid = 1'b0;
    chk("t4_still_full", {31'd0, s_tready}, 32'd0);
    chk("t4_stall_valid", {31'd0, m_tvalid}, 32'd1);
    chk("t4_stall_level_c", heater_on_num, 32'd1);
    m_tready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      wait_valid(n);
      chk($sformatf("t4_hold_%0d", i), n, 32'd1);
      chk($sformatf("t4_level_%0d", i), heater_on_num, 32'(exp_lv[i]));
      chk($sformatf("t4_tdata_%0d", i), m_tdata, 32'd1);
      tick();
    end
    wait_valid(n);
    chk("t4_stop_after_4", n, 32'd1);
    chk("t4_stop_tdata", m_tdata, 32'd0);
    tick();
    chk("t4_done", {31'd0, done}, 32'd1);

    // Abort mid-HOLD with two commands queued
    s_tvalid = 1'b1; s_tdata = cmd(2, 10);
    tick();
    s_tdata = cmd(4, 3);
    tick();
    s_tdata = cmd(5, 3);
    tick();
    s_tvalid = 1'b0;
    tick(); tick();
    chk("t5_in_hold", heater_on_num, 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_stop_valid", {31'd0, m_tvalid}, 32'd1);
    chk("t5_stop_tdata", m_tdata, 32'd0);
    tick();
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    tick(); tick(); tick();
    chk("t5_flushed", {31'd0, m_tvalid}, 32'd0);

    // Reset mid-APPLY with back-pressure
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = cmd(4, 3);
    tick();
    s_tvalid = 1'b0;
    tick();
    chk("t6_apply_valid", {31'd0, m_tvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, m_tvalid}, 32'd0);
    chk("t6_rst_level", heater_on_num, 32'd0);
    chk("t6_rst_ready", {31'd0, s_tready}, 32'd0);
    chk("t6_rst_err", {31'd0, level_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    m_tready = 1'b1;
    tick();
    chk("t6_ready", {31'd0, s_tready}, 32'd1);
    tick(); tick();
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    chk("t6_idle_valid", {31'd0, m_tvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
